// File: rtl/skylark_pkg.sv
// Shared definitions for the skylark core front end.
// Provides the reset PC default, the canonical NOP word, base opcodes,
// the packed FIFO entry type and a word-alignment helper.
package skylark_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // One buffered fetch result: {PC, instruction}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle.
// Instruction-memory side: IMemReq/IMemAddr out, IMemGnt/IMemRValid/IMemRData in.
// Pipeline side: PCSrcE/PCTargetE/StallD in, ValidD/InstrD/PCD/PCPlus4D out.
// master = fetch unit, slave = memory plus surrounding pipeline.
interface fetch_unit_if;

    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    modport master (
        output IMemReq, IMemAddr,
        input  IMemGnt, IMemRValid, IMemRData,
        input  PCSrcE, PCTargetE, StallD,
        output ValidD, InstrD, PCD, PCPlus4D
    );

    modport slave (
        input  IMemReq, IMemAddr,
        output IMemGnt, IMemRValid, IMemRData,
        output PCSrcE, PCTargetE, StallD,
        input  ValidD, InstrD, PCD, PCPlus4D
    );

endinterface

// File: rtl/instr_fifo.sv
// Small circular FIFO of fetched {PC, instr} entries.
// Ports: clk, rst_n (async, active-low), flush (drops all entries, wins over
// push/pop), push/push_data, pop, head (entry at read pointer), empty, count.
module instr_fifo
    import skylark_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [IW-1:0] rd_ptr;
    logic [IW-1:0] wr_ptr;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with credit-based request issue.
// Ports: clk, rst_n (async, active-low), bus (fetch_unit_if.master) carrying
// the instruction-memory request/response channel and the Decode/Execute
// side (redirect in, stall in, buffered instruction out).
// A request is issued only while in-flight requests plus buffered
// instructions stay below MAX_OUTSTANDING, so the FIFO cannot overflow.
module fetch_unit
    import skylark_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    bus
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fpc;
    logic [31:0]   resp_pc;      // PC of the next response that will be kept
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   in_use;

    logic          grant;
    logic          rvalid;
    logic          keep;
    logic          pop;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;

    assign in_use = {1'b0, outstanding} + {1'b0, fifo_count};

    // rst_n gates the request so it is low while reset is held
    assign bus.IMemReq  = rst_n && !bus.PCSrcE && (in_use < (CW + 1)'(MAX_OUTSTANDING));
    assign bus.IMemAddr = word_align(fpc);

    assign grant  = bus.IMemReq && bus.IMemGnt;
    assign rvalid = bus.IMemRValid;
    assign keep   = rvalid && (discard_cnt == '0);
    assign pop    = !fifo_empty && !bus.StallD && !bus.PCSrcE;

    assign push_entry = '{pc: resp_pc, instr: bus.IMemRData};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rvalid);
            if (bus.PCSrcE) begin
                // Everything still in flight after this edge belongs to the
                // squashed path; a response arriving now is already counted.
                fpc         <= word_align(bus.PCTargetE);
                resp_pc     <= word_align(bus.PCTargetE);
                discard_cnt <= outstanding - CW'(rvalid);
            end else begin
                if (grant) begin
                    fpc <= fpc + 32'd4;
                end
                if (rvalid && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    instr_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.PCSrcE),
        .push      (keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.ValidD   = !fifo_empty;
    assign bus.InstrD   = fifo_head.instr;
    assign bus.PCD      = fifo_head.pc;
    assign bus.PCPlus4D = fifo_empty ? '0 : fifo_head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based reference of the
// memory and the instruction buffer, plus a second instance with a
// wrapping RESET_PC.
module tb_fetch_unit;

    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RP       = 32'h0000_0000;
    localparam logic [31:0] RP_WRAP  = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int unsigned ready;
        bit          stale;
    } req_t;

    logic clk;
    logic rst_n;
    logic rst2_n;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(RP), .MAX_OUTSTANDING(MAX_OUT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(RP_WRAP), .MAX_OUTSTANDING(MAX_OUT)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned cyc      = 0;

    req_t        inflight[$];
    logic [31:0] buf_q[$];
    logic [31:0] exp_fpc;

    int unsigned gnt_pct, stall_pct, redir_pct, lat_min, lat_max;
    bit          force_redir = 1'b0;
    logic [31:0] force_tgt   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // One clock cycle; entered and left at a falling edge.
    task automatic step();
        bit          redir, stall, gnt, rv, grant, consume;
        logic [31:0] tgt;
        int unsigned lat;
        req_t        e;

        redir = force_redir || ($urandom_range(99) < redir_pct);
        tgt   = force_redir ? force_tgt : $urandom;
        stall = $urandom_range(99) < stall_pct;
        gnt   = $urandom_range(99) < gnt_pct;
        rv    = (inflight.size() != 0) && (inflight[0].ready <= cyc);
        lat   = $urandom_range(lat_max, lat_min);

        bus.PCSrcE     = redir;
        bus.PCTargetE  = tgt;
        bus.StallD     = stall;
        bus.IMemGnt    = gnt;
        bus.IMemRValid = rv;
        bus.IMemRData  = rv ? mem_word(inflight[0].addr) : $urandom;
        #1;

        check("imem_req", 32'(bus.IMemReq),
              32'(((inflight.size() + buf_q.size()) < MAX_OUT) && !redir));
        check("valid_d", 32'(bus.ValidD), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            check("pcd", bus.PCD, buf_q[0]);
            check("instr_d", bus.InstrD, mem_word(buf_q[0]));
            check("pcplus4_d", bus.PCPlus4D, buf_q[0] + 32'd4);
        end
        check("fifo_cap", 32'(u_dut.fifo_count <= MAX_OUT), 32'd1);

        grant   = bus.IMemReq && gnt;
        consume = (buf_q.size() != 0) && !stall && !redir;
        if (grant) check("imem_addr", bus.IMemAddr, exp_fpc);

        if (consume) void'(buf_q.pop_front());
        if (rv) begin
            e = inflight.pop_front();
            if (!e.stale && !redir) buf_q.push_back(e.addr);
        end
        if (grant) begin
            inflight.push_back('{addr: exp_fpc, ready: cyc + lat, stale: 1'b0});
            exp_fpc = exp_fpc + 32'd4;
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            buf_q.delete();
            exp_fpc = {tgt[31:2], 2'b00};
        end

        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input int unsigned g, input int unsigned s,
                       input int unsigned r, input int unsigned lmin, input int unsigned lmax);
        gnt_pct   = g;
        stall_pct = s;
        redir_pct = r;
        lat_min   = lmin;
        lat_max   = lmax;
        repeat (n) step();
    endtask

    // Entered at a falling edge; asserts reset between edges so the clear is
    // observed without any clock, and releases it at a later falling edge.
    task automatic apply_reset();
        #2;
        rst_n          = 1'b0;
        bus.IMemRValid = 1'b0;
        bus.IMemGnt    = 1'b0;
        bus.PCSrcE     = 1'b0;
        bus.StallD     = 1'b0;
        #1;
        check("rst_req", 32'(bus.IMemReq), 32'd0);
        check("rst_valid", 32'(bus.ValidD), 32'd0);
        check("rst_instr", bus.InstrD, 32'd0);
        check("rst_pcd", bus.PCD, 32'd0);
        check("rst_pc4", bus.PCPlus4D, 32'd0);
        inflight.delete();
        buf_q.delete();
        exp_fpc = RP;
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_req", 32'(bus.IMemReq), 32'd0);
        check("rst_hold_valid", 32'(bus.ValidD), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] wrap_addr[$];
        bit          pend2;
        logic [31:0] pend2_addr;
        bit          seen_wrap;

        rst_n           = 1'b0;
        rst2_n          = 1'b0;
        bus.IMemGnt     = 1'b0;
        bus.IMemRValid  = 1'b0;
        bus.IMemRData   = '0;
        bus.PCSrcE      = 1'b0;
        bus.PCTargetE   = '0;
        bus.StallD      = 1'b0;
        bus2.IMemGnt    = 1'b0;
        bus2.IMemRValid = 1'b0;
        bus2.IMemRData  = '0;
        bus2.PCSrcE     = 1'b0;
        bus2.PCTargetE  = '0;
        bus2.StallD     = 1'b0;

        @(negedge clk);
        apply_reset();

        // Streaming, always-grant, 1-cycle latency
        run(10, 100, 0, 0, 1, 1);
        // Stall with buffer full, then release
        run(5, 100, 100, 0, 1, 1);
        run(8, 100, 0, 0, 1, 1);

        // Two requests in flight, then redirect to 0x100
        run(6, 0, 0, 0, 1, 1);
        run(2, 100, 0, 0, 4, 4);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0100;
        step();
        force_redir = 1'b0;
        run(12, 100, 0, 0, 1, 1);

        // Grant withheld, then variable latency
        run(3, 0, 0, 0, 1, 4);
        run(40, 100, 20, 0, 1, 4);

        // Mixed random traffic
        run(2000, 70, 30, 3, 1, 4);

        // Reset mid-stream with two in flight
        run(6, 0, 0, 0, 1, 1);
        run(2, 100, 0, 0, 4, 4);
        apply_reset();
        run(30, 80, 25, 2, 1, 4);

        // Wrapping reset PC instance: always grant, 1-cycle latency
        pend2      = 1'b0;
        pend2_addr = '0;
        seen_wrap  = 1'b0;
        rst2_n     = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus2.IMemGnt    = 1'b1;
            bus2.IMemRValid = pend2;
            bus2.IMemRData  = mem_word(pend2_addr);
            #1;
            if (bus2.IMemReq) wrap_addr.push_back(bus2.IMemAddr);
            if (bus2.ValidD && (bus2.PCD == 32'hFFFF_FFFC)) begin
                check("wrap_pc4", bus2.PCPlus4D, 32'h0000_0000);
                seen_wrap = 1'b1;
            end
            pend2      = bus2.IMemReq;
            pend2_addr = bus2.IMemAddr;
            @(negedge clk);
        end
        check("wrap_count", 32'(wrap_addr.size() >= 3), 32'd1);
        if (wrap_addr.size() >= 3) begin
            check("wrap_a0", wrap_addr[0], 32'hFFFF_FFF8);
            check("wrap_a1", wrap_addr[1], 32'hFFFF_FFFC);
            check("wrap_a2", wrap_addr[2], 32'h0000_0000);
        end
        check("wrap_seen", 32'(seen_wrap), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
